// File: rtl/fifo_pkg.sv
// Shared widths and types for the FIFO read-side stream master.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;
    typedef logic [1:0]                    buf_cnt_t;

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream, bundled for the reader.
interface fifo_stream_reader_if #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DEFAULT_DATA_WIDTH
);

    logic                  fifo_empty;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  m_ready,
        output fifo_rd_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output m_ready,
        input  fifo_rd_en,
        input  m_valid,
        input  m_data
    );

endinterface

// File: rtl/fifo_rd_skid_buf.sv
// Two-entry first-word-fall-through register buffer; entry0 is always the head.
module fifo_rd_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output buf_cnt_t              count,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] entry0_q, entry0_d;
    logic [DATA_WIDTH-1:0] entry1_q, entry1_d;
    buf_cnt_t              count_q, count_d;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) entry0_d = push_data;
                else                 entry1_d = push_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                entry0_d = entry1_q;
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop: shift the tail forward when full, else the new word becomes head.
                if (count_q == 2'd2) begin
                    entry0_d = entry1_q;
                    entry1_d = push_data;
                end else begin
                    entry0_d = push_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= '0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && count_q == 2'd2 && !pop));
        end
    end

    assign count     = count_q;
    assign head_data = entry0_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: credit-limited reads, latency absorption, stream out.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    fifo_stream_reader_if.master   bus,
    output logic                   idle,
    output logic [COUNT_WIDTH-1:0] word_count
);

    buf_cnt_t               buf_count;
    logic [DATA_WIDTH-1:0]  head_data;
    logic                   m_valid;
    logic                   pop;
    logic                   rd_en;
    logic [2:0]             credit_used;
    logic [2:0]             credit_limit;
    logic                   inflight_q, inflight_d;
    logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;

    fifo_rd_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid_buf (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_q),
        .push_data(bus.fifo_rd_data),
        .pop      (pop),
        .count    (buf_count),
        .head_data(head_data)
    );

    always_comb begin
        m_valid      = (buf_count != 2'd0);
        pop          = m_valid & bus.m_ready;
        credit_used  = {1'b0, buf_count} + {2'b00, inflight_q};
        credit_limit = 3'd2 + {2'b00, pop};
        // m_ready reaches fifo_rd_en combinationally through pop; keeps full-rate flow with a 2-deep buffer.
        rd_en        = !rst & enable & !bus.fifo_empty & (credit_used < credit_limit);
        inflight_d   = rd_en;
        word_count_d = word_count_q + COUNT_WIDTH'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            inflight_q   <= inflight_d;
            word_count_q <= word_count_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = m_valid;
    assign bus.m_data     = head_data;
    assign idle           = (buf_count == 2'd0) & !inflight_q;
    assign word_count     = word_count_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a registered-read FIFO model per instance.
module tb_fifo_stream_reader;
    import fifo_pkg::*;

    localparam int unsigned DW = DEFAULT_DATA_WIDTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        enable2;
    logic        idle;
    logic        idle2;
    logic [15:0] word_count;
    logic [3:0]  word_count2;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();
    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus2 ();

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .COUNT_WIDTH(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .bus       (bus),
        .idle      (idle),
        .word_count(word_count)
    );

    fifo_stream_reader #(
        .DATA_WIDTH (DW),
        .COUNT_WIDTH(4)
    ) dut_wrap (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable2),
        .bus       (bus2),
        .idle      (idle2),
        .word_count(word_count2)
    );

    // FIFO models: one-cycle registered read data, flushed by rst.
    data_t       mem  [0:255];
    data_t       mem2 [0:255];
    int unsigned wr_ptr = 0, rd_ptr = 0;
    int unsigned wr2 = 0, rd2 = 0;

    assign bus.fifo_empty  = (rd_ptr == wr_ptr);
    assign bus2.fifo_empty = (rd2 == wr2);

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 0;
        end else if (bus.fifo_rd_en) begin
            bus.fifo_rd_data <= mem[rd_ptr[7:0]];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            rd2 <= 0;
        end else if (bus2.fifo_rd_en) begin
            bus2.fifo_rd_data <= mem2[rd2[7:0]];
            rd2               <= rd2 + 1;
        end
    end

    data_t       got [$];
    int unsigned rd_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            got.delete();
            rd_cnt = 0;
        end else begin
            if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
            if (bus.fifo_rd_en) rd_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        enable      = 1'b0;
        bus.m_ready = 1'b0;
        wr_ptr      = 0;
        wr2         = 0;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr[7:0]] = base + 8'(i);
            wr_ptr           = wr_ptr + 1;
        end
    endtask

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        enable2      = 1'b0;
        bus.m_ready  = 1'b0;
        bus2.m_ready = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_rd_en",      bus.fifo_rd_en, 0);
        chk("rst_m_valid",    bus.m_valid, 0);
        chk("rst_m_data",     bus.m_data, 0);
        chk("rst_idle",       idle, 1);
        chk("rst_word_count", word_count, 0);
        rst = 1'b0;
        tick();

        // Back-to-back delivery of 0x11..0x18.
        do_reset();
        load(8, 8'h11);
        enable      = 1'b1;
        bus.m_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            #1;
            chk("b2b_rd_en",   bus.fifo_rd_en, 32'(t < 8));
            chk("b2b_m_valid", bus.m_valid, 32'(t >= 2 && t < 10));
            if (t >= 2 && t < 10) chk("b2b_m_data", bus.m_data, 32'h11 + 32'(t - 2));
            tick();
        end
        chk("b2b_word_count", word_count, 8);
        chk("b2b_idle",       idle, 1);
        chk("b2b_rd_cnt",     rd_cnt, 8);

        // Back-pressure: two reads fill the buffer, head held stable.
        do_reset();
        load(6, 8'hA0);
        enable      = 1'b1;
        bus.m_ready = 1'b0;
        for (int t = 0; t < 10; t++) begin
            #1;
            chk("bp_rd_en", bus.fifo_rd_en, 32'(t < 2));
            if (t >= 2) begin
                chk("bp_m_valid_hold", bus.m_valid, 1);
                chk("bp_m_data_hold",  bus.m_data, 32'hA0);
            end
            tick();
        end
        chk("bp_rd_cnt_full", rd_cnt, 2);
        chk("bp_not_idle",    idle, 0);
        bus.m_ready = 1'b1;
        for (int t = 10; t < 17; t++) begin
            #1;
            chk("bp_rel_m_valid", bus.m_valid, 32'(t < 16));
            if (t < 16) chk("bp_rel_m_data", bus.m_data, 32'hA0 + 32'(t - 10));
            tick();
        end
        chk("bp_rd_cnt_total", rd_cnt, 6);
        chk("bp_word_count",   word_count, 6);

        // Random ready over 200 incrementing words.
        do_reset();
        for (int i = 0; i < 200; i++) mem[i] = 8'(i);
        wr_ptr = 200;
        enable = 1'b1;
        begin
            int cyc;
            cyc = 0;
            while (got.size() < 200 && cyc < 3000) begin
                bus.m_ready = 1'($urandom_range(0, 1));
                tick();
                cyc++;
            end
            chk("rnd_timeout", 32'(cyc < 3000), 1);
        end
        bus.m_ready = 1'b0;
        tick();
        tick();
        chk("rnd_count", got.size(), 200);
        for (int k = 0; k < got.size(); k++) chk("rnd_data", got[k], 32'(k[7:0]));
        chk("rnd_word_count", word_count, 200);
        chk("rnd_rd_cnt",     rd_cnt, 200);

        // Empty FIFO throughout.
        do_reset();
        enable      = 1'b1;
        bus.m_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            #1;
            chk("empty_rd_en",   bus.fifo_rd_en, 0);
            chk("empty_m_valid", bus.m_valid, 0);
            chk("empty_idle",    idle, 1);
            tick();
        end

        // enable drops the cycle after a read is issued.
        do_reset();
        load(3, 8'h55);
        enable      = 1'b1;
        bus.m_ready = 1'b0;
        #1;
        chk("en_rd_issued", bus.fifo_rd_en, 1);
        tick();
        enable = 1'b0;
        #1;
        chk("en_rd_stopped",   bus.fifo_rd_en, 0);
        chk("en_inflight_busy", idle, 0);
        tick();
        for (int t = 0; t < 4; t++) begin
            #1;
            chk("en_captured_valid", bus.m_valid, 1);
            chk("en_captured_data",  bus.m_data, 32'h55);
            chk("en_no_rd",          bus.fifo_rd_en, 0);
            tick();
        end
        chk("en_rd_cnt", rd_cnt, 1);
        bus.m_ready = 1'b1;
        #1;
        chk("en_deliver_data", bus.m_data, 32'h55);
        chk("en_no_rd_ready",  bus.fifo_rd_en, 0);
        tick();
        #1;
        chk("en_drained_valid", bus.m_valid, 0);
        chk("en_drained_idle",  idle, 1);
        chk("en_word_count",    word_count, 1);
        chk("en_got_size",      got.size(), 1);
        if (got.size() >= 1) chk("en_got_data", got[0], 32'h55);
        tick();

        // Reset mid-stream with a buffered word and a read in flight.
        do_reset();
        load(6, 8'hC0);
        enable      = 1'b1;
        bus.m_ready = 1'b1;
        tick();
        tick();
        tick();
        #1;
        chk("mid_pre_valid", bus.m_valid, 1);
        chk("mid_pre_idle",  idle, 0);
        chk("mid_pre_count", word_count, 1);
        chk("mid_pre_rd_en", bus.fifo_rd_en, 1);
        rst    = 1'b1;
        wr_ptr = 0;
        #1;
        chk("mid_rst_rd_en", bus.fifo_rd_en, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_post_valid", bus.m_valid, 0);
        chk("mid_post_count", word_count, 0);
        chk("mid_post_idle",  idle, 1);
        chk("mid_post_data",  bus.m_data, 0);
        load(2, 8'h31);
        for (int t = 0; t < 20 && got.size() < 2; t++) tick();
        chk("mid_resume_size", got.size(), 2);
        if (got.size() >= 2) begin
            chk("mid_resume_d0", got[0], 32'h31);
            chk("mid_resume_d1", got[1], 32'h32);
        end
        chk("mid_resume_count", word_count, 2);

        // 17 words through a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) mem2[i] = 8'(8'h40 + i);
        wr2          = 17;
        enable2      = 1'b1;
        bus2.m_ready = 1'b1;
        for (int t = 0; t < 25; t++) tick();
        chk("wrap_word_count", word_count2, 1);
        chk("wrap_idle",       idle2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
